// File: rtl/codec_init_sequencer_pkg.sv
// Shared constants and types for the audio-codec control sequencer:
// register map, init data values, FSM state set and the register-write record.
package codec_pkg;

  localparam logic [6:0] CODEC_ADDR_DEFAULT = 7'h34;

  localparam logic [6:0] R0  = 7'd0;
  localparam logic [6:0] R1  = 7'd1;
  localparam logic [6:0] R2  = 7'd2;
  localparam logic [6:0] R3  = 7'd3;
  localparam logic [6:0] R4  = 7'd4;
  localparam logic [6:0] R5  = 7'd5;
  localparam logic [6:0] R6  = 7'd6;
  localparam logic [6:0] R7  = 7'd7;
  localparam logic [6:0] R8  = 7'd8;
  localparam logic [6:0] R9  = 7'd9;
  localparam logic [6:0] R10 = 7'd10;
  localparam logic [6:0] R11 = 7'd11;
  localparam logic [6:0] R12 = 7'd12;
  localparam logic [6:0] R13 = 7'd13;
  localparam logic [6:0] R14 = 7'd14;
  localparam logic [6:0] R15 = 7'd15;
  localparam logic [6:0] R16 = 7'd16;
  localparam logic [6:0] R17 = 7'd17;
  localparam logic [6:0] R18 = 7'd18;

  localparam logic [7:0] SOFT_RESET          = 8'h00;
  localparam logic [7:0] PLAYBACK_ONLY       = 8'h67;
  localparam logic [7:0] ANALOGUE_AUDIO_PATH = 8'h12;
  localparam logic [7:0] DIGITAL_AUDIO_PATH  = 8'h04;
  localparam logic [7:0] DIGITAL_AUDIO_IF    = 8'h02;
  localparam logic [7:0] SAMPLING_RATE       = 8'h10;
  localparam logic [7:0] ACTIVATE            = 8'h01;

  localparam int INIT_LEN = 7;

  typedef enum logic [2:0] {
    ST_IDLE, ST_ISSUE, ST_WAIT_ACK, ST_GAP, ST_DONE, ST_VOL_L, ST_VOL_R, ST_ERROR
  } state_e;

  // Which write is in flight, so a retry re-enters the right issue state.
  typedef enum logic [1:0] {SRC_INIT, SRC_VOL_L, SRC_VOL_R} src_e;

  typedef struct packed {
    logic [6:0] reg_addr;
    logic [7:0] data;
  } reg_write_t;

endpackage

// File: rtl/codec_init_sequencer_if.sv
// Request/response bundle between the codec sequencer and the shared I2C master.
interface codec_init_sequencer_if;
  logic       i2c_start;
  logic [6:0] i2c_slave_addr;
  logic [6:0] i2c_reg_addr;
  logic [7:0] i2c_data;
  logic       i2c_done;
  logic       i2c_ack_ok;

  modport master (
    output i2c_start, i2c_slave_addr, i2c_reg_addr, i2c_data,
    input  i2c_done, i2c_ack_ok
  );

  modport slave (
    input  i2c_start, i2c_slave_addr, i2c_reg_addr, i2c_data,
    output i2c_done, i2c_ack_ok
  );
endinterface

// File: rtl/codec_init_rom.sv
// Fixed codec bring-up table: entry index -> register write.
module codec_init_rom
  import codec_pkg::*;
(
  input  logic [2:0]  i_idx,
  output reg_write_t  o_entry
);

  always_comb begin
    // NOTE: default assignment first so no path through the case leaves o_entry unassigned (no latch).
    o_entry = '{reg_addr: R15, data: SOFT_RESET};
    case (i_idx)
      3'd0:    o_entry = '{reg_addr: R15, data: SOFT_RESET};
      3'd1:    o_entry = '{reg_addr: R6,  data: PLAYBACK_ONLY};
      3'd2:    o_entry = '{reg_addr: R4,  data: ANALOGUE_AUDIO_PATH};
      3'd3:    o_entry = '{reg_addr: R5,  data: DIGITAL_AUDIO_PATH};
      3'd4:    o_entry = '{reg_addr: R7,  data: DIGITAL_AUDIO_IF};
      3'd5:    o_entry = '{reg_addr: R8,  data: SAMPLING_RATE};
      3'd6:    o_entry = '{reg_addr: R9,  data: ACTIVATE};
      default: o_entry = '{reg_addr: R15, data: SOFT_RESET};
    endcase
  end

endmodule

// File: rtl/codec_init_sequencer.sv
// Walks the codec init table over the I2C master, then serves DAC-volume
// updates as R2/R3 write pairs, with per-write retry and timeout.
module codec_init_sequencer
  import codec_pkg::*;
#(
  parameter logic [6:0] CODEC_ADDR     = CODEC_ADDR_DEFAULT,
  parameter int         GAP_CYCLES     = 16,
  parameter int         TIMEOUT_CYCLES = 4096,
  parameter int         MAX_RETRY      = 3
) (
  input  logic                   clock,
  input  logic                   reset_n,
  input  logic                   start,
  input  logic                   vol_wr,
  input  logic [7:0]             vol_l,
  input  logic [7:0]             vol_r,
  codec_init_sequencer_if.master i2c,
  output logic                   busy,
  output logic                   cfg_done,
  output logic                   cfg_error
);

  localparam int TMR_W = $clog2(TIMEOUT_CYCLES) + 1;
  localparam int GAP_W = $clog2(GAP_CYCLES) + 1;
  localparam int RTY_W = $clog2(MAX_RETRY) + 1;

  localparam logic [2:0] S_IDLE     = ST_IDLE;
  localparam logic [2:0] S_ISSUE    = ST_ISSUE;
  localparam logic [2:0] S_WAIT_ACK = ST_WAIT_ACK;
  localparam logic [2:0] S_GAP      = ST_GAP;
  localparam logic [2:0] S_DONE     = ST_DONE;
  localparam logic [2:0] S_VOL_L    = ST_VOL_L;
  localparam logic [2:0] S_VOL_R    = ST_VOL_R;
  localparam logic [2:0] S_ERROR    = ST_ERROR;

  logic [2:0]       r_state;
  logic [2:0]       r_idx;
  logic [RTY_W-1:0] r_retry;
  logic [TMR_W-1:0] r_timer;
  logic [GAP_W-1:0] r_gap;
  logic             r_ok;
  src_e             r_src;
  logic [7:0]       r_vol_l;
  logic [7:0]       r_vol_r;
  logic             r_cfg_done;
  logic             r_cfg_error;

  reg_write_t w_rom_entry;
  reg_write_t w_entry;
  logic       w_issue;
  logic       w_busy;
  logic       w_fail;
  logic       w_gap_end;
  logic [2:0] w_issue_state;

  codec_init_rom u_rom (
    .i_idx   (r_idx),
    .o_entry (w_rom_entry)
  );

  always_comb begin
    w_entry       = w_rom_entry;
    w_issue_state = S_ISSUE;
    case (r_src)
      SRC_VOL_L: begin
        w_entry       = '{reg_addr: R2, data: r_vol_l};
        w_issue_state = S_VOL_L;
      end
      SRC_VOL_R: begin
        w_entry       = '{reg_addr: R3, data: r_vol_r};
        w_issue_state = S_VOL_R;
      end
      default: begin
        w_entry       = w_rom_entry;
        w_issue_state = S_ISSUE;
      end
    endcase
  end

  assign w_issue   = (r_state == S_ISSUE) || (r_state == S_VOL_L) || (r_state == S_VOL_R);
  assign w_busy    = !((r_state == S_IDLE) || (r_state == S_DONE) || (r_state == S_ERROR));
  // A done pulse decides the attempt; without one, only the timer can fail it.
  assign w_fail    = i2c.i2c_done ? !i2c.i2c_ack_ok
                                  : (r_timer == TMR_W'(TIMEOUT_CYCLES - 1));
  assign w_gap_end = (r_gap == GAP_W'(GAP_CYCLES - 1));

  assign i2c.i2c_start      = w_issue;
  assign i2c.i2c_slave_addr = CODEC_ADDR;
  assign i2c.i2c_reg_addr   = w_busy ? w_entry.reg_addr : '0;
  assign i2c.i2c_data       = w_busy ? w_entry.data     : '0;

  assign busy      = w_busy;
  assign cfg_done  = r_cfg_done;
  assign cfg_error = r_cfg_error;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= S_IDLE;
      r_idx       <= '0;
      r_retry     <= '0;
      r_timer     <= '0;
      r_gap       <= '0;
      r_ok        <= 1'b0;
      r_src       <= SRC_INIT;
      r_vol_l     <= '0;
      r_vol_r     <= '0;
      r_cfg_done  <= 1'b0;
      r_cfg_error <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE, S_DONE, S_ERROR: begin
          if (start) begin
            r_idx       <= '0;
            r_retry     <= '0;
            r_src       <= SRC_INIT;
            r_cfg_done  <= 1'b0;
            r_cfg_error <= 1'b0;
            r_state     <= S_ISSUE;
          end else if (vol_wr && (r_state == S_DONE)) begin
            r_vol_l <= vol_l;
            r_vol_r <= vol_r;
            r_retry <= '0;
            r_src   <= SRC_VOL_L;
            r_state <= S_VOL_L;
          end
        end
        S_ISSUE, S_VOL_L, S_VOL_R: begin
          r_timer <= '0;
          r_state <= S_WAIT_ACK;
        end
        S_WAIT_ACK: begin
          if (i2c.i2c_done && i2c.i2c_ack_ok) begin
            r_retry <= '0;
            r_ok    <= 1'b1;
            r_gap   <= '0;
            r_state <= S_GAP;
          end else if (w_fail) begin
            if (r_retry < RTY_W'(MAX_RETRY)) begin
              r_retry <= r_retry + 1'b1;
              r_ok    <= 1'b0;
              r_gap   <= '0;
              r_state <= S_GAP;
            end else begin
              r_cfg_done  <= 1'b0;
              r_cfg_error <= 1'b1;
              r_state     <= S_ERROR;
            end
          end else begin
            r_timer <= r_timer + 1'b1;
          end
        end
        S_GAP: begin
          if (!w_gap_end) begin
            r_gap <= r_gap + 1'b1;
          end else if (!r_ok) begin
            r_state <= w_issue_state;
          end else begin
            case (r_src)
              SRC_INIT: begin
                if (r_idx == 3'(INIT_LEN - 1)) begin
                  r_cfg_done <= 1'b1;
                  r_state    <= S_DONE;
                end else begin
                  r_idx   <= r_idx + 3'd1;
                  r_state <= S_ISSUE;
                end
              end
              SRC_VOL_L: begin
                r_src   <= SRC_VOL_R;
                r_state <= S_VOL_R;
              end
              default: r_state <= S_DONE;
            endcase
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule
